// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
// ps2_keyboard : PS/2 set-2 receiver, Apple-1 ASCII decoder, char FIFO, KBD/KBDCR
// Revision     : 1.0
// ============================================================================
module ps2_keyboard #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       cpu_clken,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       address,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       clr_screen,
  output logic       frame_err
);
  localparam int c_FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [c_FW-1:0] c_FILT_MAX = c_FW'(FILTER_LEN - 1);
  localparam int c_TW = $clog2(TIMEOUT);
  localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT - 1);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_CHECK = 2'd2;
  localparam logic [1:0] D_NORM = 2'd0, D_BRK = 2'd1, D_EXT = 2'd2, D_EXT_BRK = 2'd3;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2, r_clk_filt;
  logic [c_FW-1:0] r_filt_cnt;
  logic            w_fall;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign w_fall = r_clk_filt && !r_clk_s2 && (r_filt_cnt == c_FILT_MAX);

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_clk_filt <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2 == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_MAX) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  logic [1:0]      r_rx_state;
  logic [3:0]      r_bit_cnt;
  logic [9:0]      r_shift;
  logic            r_start;
  logic [c_TW-1:0] r_to_cnt;
  logic            r_frame_err;
  logic            w_frame_ok, w_rx_valid;
  logic [7:0]      w_rx_byte;

  // r_shift holds data[7:0], parity, stop once ten bits have followed the start bit
  assign w_frame_ok = !r_start && r_shift[9] && (^r_shift[8:0]);
  assign w_rx_valid = (r_rx_state == S_CHECK) && w_frame_ok;
  assign w_rx_byte  = r_shift[7:0];

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_rx_state  <= S_IDLE;
      r_bit_cnt   <= 4'd0;
      r_shift     <= '0;
      r_start     <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (w_fall) begin
            r_start    <= r_dat_s2;
            r_bit_cnt  <= 4'd1;
            r_rx_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            r_shift   <= {r_dat_s2, r_shift[9:1]};
            r_to_cnt  <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd10) r_rx_state <= S_CHECK;
          end else if (r_to_cnt == c_TO_MAX) begin
            r_rx_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_frame_err <= !w_frame_ok;
          r_rx_state  <= S_IDLE;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // Returns {hit, ascii}; letters carry no separate shifted form
  function automatic logic [7:0] map_key(input logic [7:0] code, input logic sh);
    logic [6:0] lo, hi;
    logic       hit;
    hit = 1'b1;
    lo  = 7'h00;
    hi  = 7'h00;
    case (code)
      8'h1C: lo = 7'h41;  8'h32: lo = 7'h42;  8'h21: lo = 7'h43;  8'h23: lo = 7'h44;
      8'h24: lo = 7'h45;  8'h2B: lo = 7'h46;  8'h34: lo = 7'h47;  8'h33: lo = 7'h48;
      8'h43: lo = 7'h49;  8'h3B: lo = 7'h4A;  8'h42: lo = 7'h4B;  8'h4B: lo = 7'h4C;
      8'h3A: lo = 7'h4D;  8'h31: lo = 7'h4E;  8'h44: lo = 7'h4F;  8'h4D: lo = 7'h50;
      8'h15: lo = 7'h51;  8'h2D: lo = 7'h52;  8'h1B: lo = 7'h53;  8'h2C: lo = 7'h54;
      8'h3C: lo = 7'h55;  8'h2A: lo = 7'h56;  8'h1D: lo = 7'h57;  8'h22: lo = 7'h58;
      8'h35: lo = 7'h59;  8'h1A: lo = 7'h5A;
      8'h16: {lo, hi} = {7'h31, 7'h21};
      8'h1E: {lo, hi} = {7'h32, 7'h40};
      8'h26: {lo, hi} = {7'h33, 7'h23};
      8'h25: {lo, hi} = {7'h34, 7'h24};
      8'h2E: {lo, hi} = {7'h35, 7'h25};
      8'h36: {lo, hi} = {7'h36, 7'h5E};
      8'h3D: {lo, hi} = {7'h37, 7'h26};
      8'h3E: {lo, hi} = {7'h38, 7'h2A};
      8'h46: {lo, hi} = {7'h39, 7'h28};
      8'h45: {lo, hi} = {7'h30, 7'h29};
      8'h4E: {lo, hi} = {7'h2D, 7'h5F};
      8'h55: {lo, hi} = {7'h3D, 7'h2B};
      8'h54: {lo, hi} = {7'h5B, 7'h7B};
      8'h5B: {lo, hi} = {7'h5D, 7'h7D};
      8'h5D: {lo, hi} = {7'h5C, 7'h7C};
      8'h4C: {lo, hi} = {7'h3B, 7'h3A};
      8'h52: {lo, hi} = {7'h27, 7'h22};
      8'h41: {lo, hi} = {7'h2C, 7'h3C};
      8'h49: {lo, hi} = {7'h2E, 7'h3E};
      8'h4A: {lo, hi} = {7'h2F, 7'h3F};
      8'h0E: {lo, hi} = {7'h60, 7'h7E};
      8'h29: lo = 7'h20;  8'h5A: lo = 7'h0D;  8'h66: lo = 7'h5F;  8'h76: lo = 7'h1B;
      default: hit = 1'b0;
    endcase
    if (hi == 7'h00) hi = lo;
    return {hit, sh ? hi : lo};
  endfunction

  logic [1:0] r_dec_state;
  logic       r_shift_key, r_ctrl_key, r_char_valid, r_clr_screen;
  logic [6:0] r_char;
  logic [7:0] w_map;
  logic       w_letter, w_is_shift;

  assign w_map      = map_key(w_rx_byte, r_shift_key);
  assign w_letter   = (w_map[6:0] >= 7'h41) && (w_map[6:0] <= 7'h5A);
  assign w_is_shift = (w_rx_byte == 8'h12) || (w_rx_byte == 8'h59);

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      r_dec_state  <= D_NORM;
      r_shift_key  <= 1'b0;
      r_ctrl_key   <= 1'b0;
      r_char_valid <= 1'b0;
      r_char       <= 7'h00;
      r_clr_screen <= 1'b0;
    end else begin
      r_char_valid <= 1'b0;
      r_clr_screen <= 1'b0;
      if (w_rx_valid) begin
        if (w_rx_byte == 8'hF0 && r_dec_state == D_NORM) begin
          r_dec_state <= D_BRK;
        end else if (w_rx_byte == 8'hF0 && r_dec_state == D_EXT) begin
          r_dec_state <= D_EXT_BRK;
        end else if (w_rx_byte == 8'hE0 && r_dec_state == D_NORM) begin
          r_dec_state <= D_EXT;
        end else begin
          r_dec_state <= D_NORM;
          case (r_dec_state)
            D_NORM: begin
              if (w_is_shift) r_shift_key <= 1'b1;
              else if (w_rx_byte == 8'h14) r_ctrl_key <= 1'b1;
              else if (w_rx_byte == 8'h05) r_clr_screen <= 1'b1;
              else if (w_map[7]) begin
                r_char_valid <= 1'b1;
                r_char <= (r_ctrl_key && w_letter) ? {2'b00, w_map[4:0]} : w_map[6:0];
              end
            end
            D_BRK: begin
              if (w_is_shift) r_shift_key <= 1'b0;
              else if (w_rx_byte == 8'h14) r_ctrl_key <= 1'b0;
            end
            D_EXT:   if (w_rx_byte == 8'h14) r_ctrl_key <= 1'b1;
            default: if (w_rx_byte == 8'h14) r_ctrl_key <= 1'b0;
          endcase
        end
      end
    end
  end

  logic [6:0]      r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            w_avail, w_full, w_pop, w_push;

  assign w_avail = (r_count != '0);
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = r_en && cpu_clken && !address && w_avail;
  // When full, a simultaneous pop frees the slot being overwritten
  assign w_push  = r_char_valid && (!w_full || w_pop);

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 7'h00;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_char;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  assign dout       = address ? {w_avail, 7'b0} : {1'b1, r_mem[r_rd_ptr]};
  assign clr_screen = r_clr_screen;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire
